// File: rtl/regfile_dbg.sv
// regfile_dbg: parametrised register file with one core write port, NUM_RD
// combinational read ports with same-cycle write bypass, an optional hardwired
// zero register, a req/ack debug access port and a sequential bulk-clear engine.
module regfile_dbg #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // core write port
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  // core read ports (packed, port i at slice i)
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  // debug access port
  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [ADDR_W-1:0]        dbg_addr,
  input  logic [DATA_W-1:0]        dbg_wdata,
  output logic                     dbg_ack,
  output logic [DATA_W-1:0]        dbg_rdata,
  // bulk clear
  input  logic                     clr_start,
  output logic                     busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              dbg_ack_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              busy_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              in_idle_c;
  logic              in_clear_c;
  logic              dbg_go_c;
  logic              core_we_c;
  logic              dbg_wr_c;
  logic [DATA_W-1:0] dbg_rd_val_c;

  // Register 0 is hardwired to zero only when the parameter asks for it.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Write-enable and debug-accept decode shared by the array and the FSM.
  always_comb begin
    in_idle_c    = (state_q == ST_IDLE);
    in_clear_c   = (state_q == ST_CLEAR);
    dbg_go_c     = in_idle_c && !clr_start && dbg_req;
    core_we_c    = wr_en && !in_clear_c && !is_zero(wr_addr);
    dbg_wr_c     = dbg_go_c && dbg_we && !is_zero(dbg_addr);
    dbg_rd_val_c = is_zero(dbg_addr) ? '0 : mem_q[dbg_addr];
  end

  // Storage array: clear engine, then core write, then debug write (debug wins a tie).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_W'(i)] <= '0;
      end
    end else begin
      if (in_clear_c) begin
        mem_q[cnt_q] <= '0;
      end
      if (core_we_c) begin
        mem_q[wr_addr] <= wr_data;
      end
      if (dbg_wr_c) begin
        mem_q[dbg_addr] <= dbg_wdata;
      end
    end
  end

  // Read ports: zero register first, then same-cycle bypass, else array contents.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra_c;
    logic [DATA_W-1:0] rv_c;

    assign ra_c = rd_addr[g*ADDR_W +: ADDR_W];

    always_comb begin
      rv_c = mem_q[ra_c];
      if (is_zero(ra_c)) begin
        rv_c = '0;
      end else if (core_we_c && (wr_addr == ra_c)) begin
        rv_c = wr_data;
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = rv_c;
  end

  // Control FSM: IDLE dispatches clear (higher priority) or a debug access,
  // CLEAR walks the counter across the array, ACK is the one-cycle handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      dbg_ack_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (clr_start) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else if (dbg_req) begin
            state_q   <= ST_ACK;
            dbg_ack_q <= 1'b1;
            if (!dbg_we) begin
              dbg_rdata_q <= dbg_rd_val_c;
            end
          end
        end
        ST_CLEAR: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_dbg.sv
// tb_regfile_dbg: self-checking bench for regfile_dbg against an array model.
module tb_regfile_dbg;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic              dbg_req;
  logic              dbg_we;
  logic [AW-1:0]     dbg_addr;
  logic [DW-1:0]     dbg_wdata;
  logic              dbg_ack;
  logic [DW-1:0]     dbg_rdata;
  logic              clr_start;
  logic              busy;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] model [DEPTH];

  regfile_dbg #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .clr_start(clr_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    clr_start = 1'b0;
  endtask

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (a == '0) return '0;
    return model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic core_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a != '0) model[a] = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got %b exp 0", dbg_ack); end
    total++; if (dbg_rdata !== '0) begin bad++; $display("FAIL reset_rdata got %h exp 0", dbg_rdata); end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {AW'(DEPTH - 1 - a), AW'(a)};
      #1;
      total++; if (rd_data[DW-1:0] !== 16'h0) begin bad++; $display("FAIL reset_p0 r%0d got %h exp 0", a, rd_data[DW-1:0]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    core_write(4'd4, 16'h0010);
    core_write(4'd5, 16'h0003);
    rd_addr = {4'd5, 4'd4};
    #1;
    total++; if (rd_data[DW-1:0] !== 16'h0010) begin bad++; $display("FAIL wr_rd_p0 got %h exp 0010", rd_data[DW-1:0]); end
    total++; if (rd_data[2*DW-1:DW] !== 16'h0003) begin bad++; $display("FAIL wr_rd_p1 got %h exp 0003", rd_data[2*DW-1:DW]); end
    tick();
  endtask

  task automatic test_bypass_zero();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hBEEF; rd_addr = {4'd4, 4'd7};
    #3;
    total++; if (rd_data[DW-1:0] !== 16'hBEEF) begin bad++; $display("FAIL bypass_p0 got %h exp beef", rd_data[DW-1:0]); end
    total++; if (rd_data[2*DW-1:DW] !== 16'h0010) begin bad++; $display("FAIL bypass_p1 got %h exp 0010", rd_data[2*DW-1:DW]); end
    tick();
    wr_en = 1'b0; model[7] = 16'hBEEF;
    #1;
    total++; if (rd_data[DW-1:0] !== 16'hBEEF) begin bad++; $display("FAIL bypass_array got %h exp beef", rd_data[DW-1:0]); end
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234; rd_addr = {4'd0, 4'd0};
    #2;
    total++; if (rd_data[DW-1:0] !== 16'h0) begin bad++; $display("FAIL zero_bypass got %h exp 0", rd_data[DW-1:0]); end
    tick();
    wr_en = 1'b0;
    #1;
    total++; if (rd_data[2*DW-1:DW] !== 16'h0) begin bad++; $display("FAIL zero_reg got %h exp 0", rd_data[2*DW-1:DW]); end
    tick();
  endtask

  task automatic test_debug();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd9; dbg_wdata = 16'hA5A5;
    #3;
    total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL dbg_ack_early got %b exp 0", dbg_ack); end
    tick();
    total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL dbg_wr_ack got %b exp 1", dbg_ack); end
    dbg_req = 1'b0; model[9] = 16'hA5A5;
    tick();
    total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL dbg_ack_width got %b exp 0", dbg_ack); end
    dbg_req = 1'b1; dbg_we = 1'b0;
    tick();
    total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL dbg_rd_ack got %b exp 1", dbg_ack); end
    total++; if (dbg_rdata !== 16'hA5A5) begin bad++; $display("FAIL dbg_rd_data got %h exp a5a5", dbg_rdata); end
    dbg_req = 1'b0;
    tick();
    total++; if (dbg_rdata !== 16'hA5A5) begin bad++; $display("FAIL dbg_rd_hold got %h exp a5a5", dbg_rdata); end
    // same-address collision: debug wins
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd9; dbg_wdata = 16'h1111;
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h2222;
    tick();
    dbg_req = 1'b0; wr_en = 1'b0; model[9] = 16'h1111;
    tick();
    rd_addr = {4'd0, 4'd9};
    #1;
    total++; if (rd_data[DW-1:0] !== 16'h1111) begin bad++; $display("FAIL dbg_core_same got %h exp 1111", rd_data[DW-1:0]); end
    // different addresses: both land
    dbg_req = 1'b1; dbg_addr = 4'd10; dbg_wdata = 16'h3333;
    wr_en = 1'b1; wr_addr = 4'd11; wr_data = 16'h4444;
    tick();
    dbg_req = 1'b0; wr_en = 1'b0; model[10] = 16'h3333; model[11] = 16'h4444;
    tick();
    rd_addr = {4'd11, 4'd10};
    #1;
    total++; if (rd_data[DW-1:0] !== 16'h3333) begin bad++; $display("FAIL dbg_core_diff_dbg got %h exp 3333", rd_data[DW-1:0]); end
    total++; if (rd_data[2*DW-1:DW] !== 16'h4444) begin bad++; $display("FAIL dbg_core_diff_core got %h exp 4444", rd_data[2*DW-1:DW]); end
    // debug read sees the pre-edge value, not the concurrent core write
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd11;
    wr_en = 1'b1; wr_addr = 4'd11; wr_data = 16'h5555;
    tick();
    total++; if (dbg_rdata !== 16'h4444) begin bad++; $display("FAIL dbg_rd_nobypass got %h exp 4444", dbg_rdata); end
    dbg_req = 1'b0; wr_en = 1'b0; model[11] = 16'h5555;
    tick();
    // zero register through debug port
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd0; dbg_wdata = 16'hFFFF;
    tick();
    dbg_req = 1'b0;
    tick();
    dbg_req = 1'b1; dbg_we = 1'b0;
    tick();
    total++; if (dbg_rdata !== 16'h0) begin bad++; $display("FAIL dbg_zero got %h exp 0", dbg_rdata); end
    // held request: ACK ignores it, IDLE starts a new transaction
    tick();
    total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL dbg_held_gap got %b exp 0", dbg_ack); end
    tick();
    total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL dbg_held_second got %b exp 1", dbg_ack); end
    dbg_req = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    int ncyc;
    int overlap;
    for (int a = 1; a < DEPTH; a++) core_write(AW'(a), DW'($urandom_range(1, 16'hFFFF)));
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL clr_busy_rise got %b exp 1", busy); end
    ncyc = 0; overlap = 0;
    while (busy === 1'b1 && ncyc < 40) begin
      if (dbg_ack === 1'b1) overlap++;
      ncyc++;
      if (ncyc == 6) begin dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd2; end
      if (ncyc == 14) begin
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h7777; rd_addr = {4'd2, 4'd2};
        #3;
        total++; if (rd_data[DW-1:0] !== 16'h0) begin bad++; $display("FAIL clr_no_bypass got %h exp 0", rd_data[DW-1:0]); end
      end
      tick();
      wr_en = 1'b0;
    end
    total++; if (ncyc != 16) begin bad++; $display("FAIL clr_busy_len got %0d exp 16", ncyc); end
    total++; if (overlap != 0) begin bad++; $display("FAIL clr_ack_overlap got %0d exp 0", overlap); end
    total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL clr_pend_early got %b exp 0", dbg_ack); end
    tick();
    total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL clr_pend_ack got %b exp 1", dbg_ack); end
    total++; if (dbg_rdata !== 16'h0) begin bad++; $display("FAIL clr_pend_rdata got %h exp 0", dbg_rdata); end
    dbg_req = 1'b0;
    model_clear();
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {AW'(DEPTH - 1 - a), AW'(a)};
      #1;
      total++; if (rd_data[DW-1:0] !== ref_read(AW'(a))) begin bad++; $display("FAIL clr_sweep r%0d got %h exp %h", a, rd_data[DW-1:0], ref_read(AW'(a))); end
    end
    tick();
  endtask

  task automatic test_priority();
    int ncyc;
    core_write(4'd6, 16'h6666);
    clr_start = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4'd6; dbg_wdata = 16'h9999;
    tick();
    clr_start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL prio_busy got %b exp 1", busy); end
    total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL prio_ack got %b exp 0", dbg_ack); end
    ncyc = 0;
    while (busy === 1'b1 && ncyc < 40) begin ncyc++; tick(); end
    total++; if (ncyc != 16) begin bad++; $display("FAIL prio_busy_len got %0d exp 16", ncyc); end
    tick();
    total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL prio_dbg_ack got %b exp 1", dbg_ack); end
    dbg_req = 1'b0;
    model_clear(); model[6] = 16'h9999;
    tick();
    rd_addr = {4'd5, 4'd6};
    #1;
    total++; if (rd_data[DW-1:0] !== 16'h9999) begin bad++; $display("FAIL prio_r6 got %h exp 9999", rd_data[DW-1:0]); end
    total++; if (rd_data[2*DW-1:DW] !== 16'h0) begin bad++; $display("FAIL prio_r5 got %h exp 0", rd_data[2*DW-1:DW]); end
    tick();
  endtask

  task automatic test_random_core();
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] e0, e1;
    for (int n = 0; n < 150; n++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = AW'($urandom); wr_data = DW'($urandom);
      ra0 = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom);
      ra1 = AW'($urandom);
      rd_addr = {ra1, ra0};
      e0 = (wr_en && ra0 != '0 && wr_addr == ra0) ? wr_data : ref_read(ra0);
      e1 = (wr_en && ra1 != '0 && wr_addr == ra1) ? wr_data : ref_read(ra1);
      #3;
      total++; if (rd_data[DW-1:0] !== e0) begin bad++; $display("FAIL rnd_p0 n%0d got %h exp %h", n, rd_data[DW-1:0], e0); end
      total++; if (rd_data[2*DW-1:DW] !== e1) begin bad++; $display("FAIL rnd_p1 n%0d got %h exp %h", n, rd_data[2*DW-1:DW], e1); end
      tick();
      if (wr_en && wr_addr != '0) model[wr_addr] = wr_data;
    end
    wr_en = 1'b0;
    tick();
  endtask

  task automatic test_random_debug();
    logic [AW-1:0] a;
    logic [DW-1:0] exp_rd;
    for (int n = 0; n < 40; n++) begin
      a = AW'($urandom);
      dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1)); dbg_addr = a; dbg_wdata = DW'($urandom);
      wr_en = 1'($urandom_range(0, 1)); wr_addr = ($urandom_range(0, 1) == 0) ? a : AW'($urandom);
      wr_data = DW'($urandom);
      exp_rd = ref_read(a);
      tick();
      total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL rdbg_ack n%0d got %b exp 1", n, dbg_ack); end
      if (!dbg_we) begin
        total++; if (dbg_rdata !== exp_rd) begin bad++; $display("FAIL rdbg_rdata n%0d got %h exp %h", n, dbg_rdata, exp_rd); end
      end
      if (wr_en && wr_addr != '0) model[wr_addr] = wr_data;
      if (dbg_we && a != '0) model[a] = dbg_wdata;
      dbg_req = 1'b0; wr_en = 1'b0;
      tick();
      rd_addr = {wr_addr, a};
      #1;
      total++; if (rd_data[DW-1:0] !== ref_read(a)) begin bad++; $display("FAIL rdbg_p0 n%0d got %h exp %h", n, rd_data[DW-1:0], ref_read(a)); end
      total++; if (rd_data[2*DW-1:DW] !== ref_read(wr_addr)) begin bad++; $display("FAIL rdbg_p1 n%0d got %h exp %h", n, rd_data[2*DW-1:DW], ref_read(wr_addr)); end
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    for (int a = 10; a < DEPTH; a++) core_write(AW'(a), DW'($urandom_range(1, 16'hFFFF)));
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd12;
    tick();
    dbg_req = 1'b0;
    tick();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_clr_busy got %b exp 0", busy); end
    total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL rst_clr_ack got %b exp 0", dbg_ack); end
    total++; if (dbg_rdata !== 16'h0) begin bad++; $display("FAIL rst_clr_rdata got %h exp 0", dbg_rdata); end
    model_clear();
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {AW'(DEPTH - 1 - a), AW'(a)};
      #1;
      total++; if (rd_data[DW-1:0] !== 16'h0) begin bad++; $display("FAIL rst_clr_sweep r%0d got %h exp 0", a, rd_data[DW-1:0]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_release_busy got %b exp 0", busy); end
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 4'd13;
    tick();
    total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL rst_release_ack got %b exp 1", dbg_ack); end
    total++; if (dbg_rdata !== 16'h0) begin bad++; $display("FAIL rst_release_rdata got %h exp 0", dbg_rdata); end
    dbg_req = 1'b0;
    tick();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_read();
    test_bypass_zero();
    test_debug();
    test_clear();
    test_priority();
    test_random_core();
    test_random_debug();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
